// File: rtl/blastn_hit_fetch_ctrl.sv
// blastn_hit_fetch_ctrl: takes one (db_pos, q_pos) seed hit at a time, reads the packed query
// word and database word that cover those positions, and forwards
// {db_pos, q_pos, db_seq, q_seq} to the seq-read unit.
// Optional same-diagonal hit deduplication is enabled by defining PROJECT_BLASTN_HIT_DEDUP_EN.
module blastn_hit_fetch_ctrl #(
  parameter int unsigned p_addr_nbits = 32,
  parameter int unsigned p_cnt_nbits  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [p_addr_nbits-1:0] q_base_addr,
  input  logic [p_addr_nbits-1:0] db_base_addr,
  input  logic [63:0]             hit_msg,
  input  logic                    hit_val,
  output logic                    hit_rdy,
  output logic [p_addr_nbits-1:0] memreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  input  logic [31:0]             memresp_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  output logic [127:0]            ostream_msg,
  output logic                    ostream_val,
  input  logic                    ostream_rdy,
  output logic [p_cnt_nbits-1:0]  hit_count,
  output logic [p_cnt_nbits-1:0]  drop_count
);

  typedef enum logic [2:0] {
    StIdle,
    StReqQ,
    StWaitQ,
    StReqD,
    StWaitD,
    StSend
  } state_e;

  state_e state_q, state_d;

  logic [31:0]             q_pos_q, db_pos_q;
  logic [31:0]             q_seq_q, db_seq_q;
  logic [p_addr_nbits-1:0] q_base_q, db_base_q;
  logic [p_cnt_nbits-1:0]  hit_count_q;
  logic [31:0]             q_word_off, db_word_off;
  logic                    drop_hit;
  logic                    accept_hit;
  logic                    send_fire;

  // Byte offset of the 16-base word holding a position: (pos / 16) * 4.
  assign q_word_off  = {2'b00, q_pos_q[31:4], 2'b00};
  assign db_word_off = {2'b00, db_pos_q[31:4], 2'b00};

`ifdef PROJECT_BLASTN_HIT_DEDUP_EN
  logic [31:0]            last_diag_q, last_db_q;
  logic                   last_vld_q;
  logic [p_cnt_nbits-1:0] drop_count_q;
  logic [31:0]            new_diag, db_delta;

  assign new_diag = hit_msg[63:32] - hit_msg[31:0];
  assign db_delta = hit_msg[63:32] - last_db_q;
  // Same diagonal and within one word ahead of the last dispatched hit: already covered.
  assign drop_hit = last_vld_q && (new_diag == last_diag_q) && (db_delta < 32'd16);

  // History of the most recently dispatched hit, and the drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_vld_q   <= 1'b0;
      last_diag_q  <= '0;
      last_db_q    <= '0;
      drop_count_q <= '0;
    end else begin
      if (send_fire) begin
        last_vld_q  <= 1'b1;
        last_diag_q <= db_pos_q - q_pos_q;
        last_db_q   <= db_pos_q;
      end
      if ((state_q == StIdle) && hit_val && drop_hit) begin
        drop_count_q <= drop_count_q + p_cnt_nbits'(1);
      end
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_hit   = 1'b0;
  assign drop_count = '0;
`endif

  assign accept_hit = (state_q == StIdle) && hit_val && !drop_hit;
  assign send_fire  = (state_q == StSend) && ostream_rdy;
  assign hit_count  = hit_count_q;

  // Next-state logic: one request/response pair per word, then a single send.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept_hit)  state_d = StReqQ;
      StReqQ:  if (memreq_rdy)  state_d = StWaitQ;
      StWaitQ: if (memresp_val) state_d = StReqD;
      StReqD:  if (memreq_rdy)  state_d = StWaitD;
      StWaitD: if (memresp_val) state_d = StSend;
      StSend:  if (ostream_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register plus the latched hit, base addresses, fetched words and hit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      q_pos_q     <= '0;
      db_pos_q    <= '0;
      q_base_q    <= '0;
      db_base_q   <= '0;
      q_seq_q     <= '0;
      db_seq_q    <= '0;
      hit_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_hit) begin
        db_pos_q  <= hit_msg[63:32];
        q_pos_q   <= hit_msg[31:0];
        q_base_q  <= q_base_addr;
        db_base_q <= db_base_addr;
      end
      if ((state_q == StWaitQ) && memresp_val) q_seq_q  <= memresp_msg;
      if ((state_q == StWaitD) && memresp_val) db_seq_q <= memresp_msg;
      if (send_fire) hit_count_q <= hit_count_q + p_cnt_nbits'(1);
    end
  end

  // Moore outputs decoded from the state and registered data only.
  always_comb begin
    hit_rdy     = (state_q == StIdle);
    memreq_val  = (state_q == StReqQ) || (state_q == StReqD);
    memresp_rdy = (state_q == StWaitQ) || (state_q == StWaitD);
    ostream_val = (state_q == StSend);
    memreq_msg  = '0;
    ostream_msg = '0;
    if (state_q == StReqQ) memreq_msg = q_base_q + p_addr_nbits'(q_word_off);
    if (state_q == StReqD) memreq_msg = db_base_q + p_addr_nbits'(db_word_off);
    if (state_q == StSend) ostream_msg = {db_pos_q, q_pos_q, db_seq_q, q_seq_q};
  end

endmodule
